riscv_divider_iter: RTL and testbench

Iterative radix-2 restoring divider executing the RV32M DIV, DIVU, REM and REMU instructions. It is the sequential counterpart to the single-cycle multiplier in the same execute stage. It shares the multiplier's opcode/operand issue interface. The result is returned on a valid-qualified writeback port after a fixed number of cycles, and the block reports busy so issue logic can stall.

---
 rtl/riscv_divider_iter_if.sv | 19 +
 rtl/riscv_divider_iter.sv | 88 ++++++++
 tb/tb_riscv_divider_iter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/riscv_divider_iter_if.sv
// riscv_divider_iter_if: issue/writeback bundle between execute-stage issue logic and the divider
interface riscv_divider_iter_if;
  logic        opcode_valid_i;
  logic [31:0] opcode_opcode_i;
  logic [31:0] opcode_ra_operand_i;
  logic [31:0] opcode_rb_operand_i;
  logic        hold_i;
  logic        writeback_valid_o;
  logic [31:0] writeback_value_o;
  logic        busy_o;
  modport master (
    output opcode_valid_i, opcode_opcode_i, opcode_ra_operand_i, opcode_rb_operand_i, hold_i,
    input  writeback_valid_o, writeback_value_o, busy_o
  );
  modport slave (
    input  opcode_valid_i, opcode_opcode_i, opcode_ra_operand_i, opcode_rb_operand_i, hold_i,
    output writeback_valid_o, writeback_value_o, busy_o
  );
endinterface

// File: rtl/riscv_divider_iter.sv
// riscv_divider_iter: 32-step restoring divider for RV32M DIV/DIVU/REM/REMU
module riscv_divider_iter (
  input logic clk_i,
  input logic rst_i,
  riscv_divider_iter_if.slave io
);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d, rem_n;
  logic [31:0] quo_q, quo_d, dvs_q, dvs_d, wb_q, wb_d, quo_n, a_abs, b_abs, spec_val, res;
  logic rsel_q, rsel_d, neg_q, neg_d;
  logic [2:0] f3;
  logic [31:0] ra, rb;
  logic [33:0] shifted, trial;
  logic is_div, accept, sgn, a_neg, b_neg, ovf, special;
  always_comb begin
    f3 = io.opcode_opcode_i[14:12];
    ra = io.opcode_ra_operand_i;
    rb = io.opcode_rb_operand_i;
    is_div = io.opcode_opcode_i[6:0] == 7'b0110011 && io.opcode_opcode_i[31:25] == 7'b0000001 && f3[2];
    accept = state_q == IDLE && io.opcode_valid_i && !io.hold_i && is_div;
    sgn = ~f3[0];
    a_neg = sgn & ra[31];
    b_neg = sgn & rb[31];
    a_abs = a_neg ? -ra : ra;
    b_abs = b_neg ? -rb : rb;
    ovf = sgn && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF;
    special = rb == 32'd0 || ovf;
    spec_val = rb == 32'd0 ? (f3[1] ? ra : 32'hFFFF_FFFF) : (f3[1] ? 32'd0 : 32'h8000_0000);
    // a negative trial difference (bit 33) means restore
    shifted = {rem_q, quo_q[31]};
    trial = shifted - {2'b00, dvs_q};
    rem_n = trial[33] ? shifted[32:0] : trial[32:0];
    quo_n = {quo_q[30:0], ~trial[33]};
    res = rsel_q ? rem_n[31:0] : quo_n;
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    wb_d = wb_q;
    rsel_d = rsel_q;
    neg_d = neg_q;
    if (accept) begin
      rsel_d = f3[1];
      neg_d = f3[1] ? a_neg : a_neg ^ b_neg;
      state_d = special ? DONE : DIV;
      wb_d = special ? spec_val : wb_q;
      cnt_d = 5'd0;
      rem_d = 33'd0;
      quo_d = a_abs;
      dvs_d = b_abs;
    end else if (!io.hold_i && state_q == DIV) begin
      rem_d = rem_n;
      quo_d = quo_n;
      cnt_d = cnt_q + 5'd1;
      state_d = cnt_q == 5'd31 ? DONE : DIV;
      wb_d = cnt_q == 5'd31 ? (neg_q ? -res : res) : wb_q;
    end else if (!io.hold_i && state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      wb_q <= '0;
      rsel_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      wb_q <= wb_d;
      rsel_q <= rsel_d;
      neg_q <= neg_d;
    end
  end
  assign io.writeback_valid_o = state_q == DONE;
  assign io.writeback_value_o = wb_q;
  assign io.busy_o = state_q != IDLE;
endmodule

// File: tb/tb_riscv_divider_iter.sv
// tb_riscv_divider_iter: directed and random divide ops checked against an arithmetic reference
module tb_riscv_divider_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  riscv_divider_iter_if dif();
  riscv_divider_iter dut (.clk_i(clk), .rst_i(rst), .io(dif.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] op_word(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic is_ovf(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (is_ovf(f3, a, b)) return f3[1] ? 32'd0 : 32'h8000_0000;
    case (f3[1:0])
      2'b00: return 32'(sa / sb);
      2'b01: return a / b;
      2'b10: return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  task automatic present(input logic [31:0] word, input logic [31:0] a, input logic [31:0] b);
    dif.opcode_valid_i = 1'b1;
    dif.opcode_opcode_i = word;
    dif.opcode_ra_operand_i = a;
    dif.opcode_rb_operand_i = b;
  endtask

  // called at a negedge; the op is accepted at the following posedge
  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input int hold_at, input int hold_len, input int inj_at, input string tag);
    int lat, bad_busy, exp_lat;
    logic [31:0] exp;
    exp = ref_res(f3, a, b);
    exp_lat = ((b == 0 || is_ovf(f3, a, b)) ? 1 : 33) + hold_len;
    present(op_word(7'b0000001, f3), a, b);
    @(negedge clk);
    dif.opcode_valid_i = 1'b0;
    lat = 1;
    bad_busy = 0;
    while (!dif.writeback_valid_o && lat < 80) begin
      if (dif.busy_o !== 1'b1) bad_busy++;
      dif.hold_i = hold_len > 0 && lat >= hold_at && lat < hold_at + hold_len;
      if (lat == inj_at) present(op_word(7'b0000001, 3'b100), 32'd999, 32'd3);
      else dif.opcode_valid_i = 1'b0;
      @(negedge clk);
      lat++;
    end
    dif.hold_i = 1'b0;
    dif.opcode_valid_i = 1'b0;
    if (dif.busy_o !== 1'b1) bad_busy++;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " value"}, dif.writeback_value_o, exp);
    chk({tag, " busy_cycles_low"}, bad_busy, 0);
    @(negedge clk);
    chk({tag, " valid_drop"}, {31'd0, dif.writeback_valid_o}, 0);
    chk({tag, " busy_drop"}, {31'd0, dif.busy_o}, 0);
  endtask

  initial begin
    int lat;
    logic [2:0] f3;
    logic [31:0] a, b;
    dif.opcode_valid_i = 1'b0;
    dif.opcode_opcode_i = '0;
    dif.opcode_ra_operand_i = '0;
    dif.opcode_rb_operand_i = '0;
    dif.hold_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset valid", {31'd0, dif.writeback_valid_o}, 0);
    chk("reset value", dif.writeback_value_o, 0);
    chk("reset busy", {31'd0, dif.busy_o}, 0);
    rst = 1'b0;
    run(3'b100, 32'd100, 32'd7, 0, 0, 0, "div_100_7");
    chk("div_100_7 literal", dif.writeback_value_o, 32'h0000_000E);
    run(3'b110, -32'd100, 32'd7, 0, 0, 0, "rem_m100_7");
    run(3'b100, -32'd100, 32'd7, 0, 0, 0, "div_m100_7");
    run(3'b101, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, "divu_max_2");
    run(3'b111, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, "remu_max_2");
    run(3'b100, 32'd5, 32'd0, 0, 0, 0, "div_by0");
    run(3'b101, 32'd5, 32'd0, 0, 0, 0, "divu_by0");
    run(3'b110, 32'd5, 32'd0, 0, 0, 0, "rem_by0");
    run(3'b111, 32'd5, 32'd0, 0, 0, 0, "remu_by0");
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div_ovf");
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "rem_ovf");
    run(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "divu_no_ovf");
    present(op_word(7'b0000001, 3'b000), 32'd100, 32'd7);
    @(negedge clk);
    dif.opcode_valid_i = 1'b0;
    chk("mul_ignored busy", {31'd0, dif.busy_o}, 0);
    chk("mul_ignored valid", {31'd0, dif.writeback_valid_o}, 0);
    present(op_word(7'b0000000, 3'b100), 32'd100, 32'd7);
    @(negedge clk);
    dif.opcode_valid_i = 1'b0;
    chk("xor_ignored busy", {31'd0, dif.busy_o}, 0);
    present(op_word(7'b0000001, 3'b100), 32'd100, 32'd7);
    dif.hold_i = 1'b1;
    @(negedge clk);
    dif.opcode_valid_i = 1'b0;
    dif.hold_i = 1'b0;
    chk("held_issue busy", {31'd0, dif.busy_o}, 0);
    run(3'b100, 32'd1000, 32'd9, 0, 0, 5, "ignore_second");
    run(3'b100, 32'd100, 32'd7, 5, 3, 0, "hold_mid");
    present(op_word(7'b0000001, 3'b101), 32'd50, 32'd5);
    @(negedge clk);
    dif.opcode_valid_i = 1'b0;
    lat = 1;
    while (!dif.writeback_valid_o && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_done latency", lat, 33);
    dif.hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_done valid", {31'd0, dif.writeback_valid_o}, 1);
      chk("hold_done value", dif.writeback_value_o, 32'd10);
    end
    dif.hold_i = 1'b0;
    @(negedge clk);
    chk("hold_done release", {31'd0, dif.writeback_valid_o}, 0);
    present(op_word(7'b0000001, 3'b100), 32'd100, 32'd7);
    @(negedge clk);
    dif.opcode_valid_i = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_reset busy", {31'd0, dif.busy_o}, 0);
    chk("mid_reset valid", {31'd0, dif.writeback_valid_o}, 0);
    chk("mid_reset value", dif.writeback_value_o, 0);
    run(3'b110, 32'd123457, 32'd100, 0, 0, 0, "after_reset");
    for (int i = 0; i < 40; i++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 200);
        4: b = -($urandom_range(1, 15));
        default: ;
      endcase
      run(f3, a, b, 0, 0, 0, "random");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
